// File: rtl/sig_gen_param_ctrl_if.sv
// Datapath-side bundle of the signal generator parameter controller.
//   master : controller side, drives the active parameter set and status,
//            receives the phase-accumulator wrap pulse.
//   slave  : DDS datapath / display side, the mirror image.
// Signals:
//   acc_wrap     1-cycle pulse, phase accumulator overflowed
//   wave_sel     active waveform (0 sine, 1 square, 2 triangle, 3 sawtooth)
//   amp_level    active amplitude level
//   freq_level   active frequency level
//   phase_off    active phase offset word
//   ftw          active tuning word
//   cfg_pending  staged set awaiting commit
//   cfg_update   1-cycle pulse the cycle after the active set loads
interface sig_gen_param_ctrl_if;
  logic        acc_wrap;
  logic [1:0]  wave_sel;
  logic [3:0]  amp_level;
  logic [3:0]  freq_level;
  logic [11:0] phase_off;
  logic [31:0] ftw;
  logic        cfg_pending;
  logic        cfg_update;

  modport master (
    input  acc_wrap,
    output wave_sel, amp_level, freq_level, phase_off, ftw, cfg_pending, cfg_update
  );

  modport slave (
    output acc_wrap,
    input  wave_sel, amp_level, freq_level, phase_off, ftw, cfg_pending, cfg_update
  );
endinterface

// File: rtl/sig_gen_param_ctrl.sv
// Front-panel parameter controller for the signal generator.
// Debounces four active-low keys, steps a staged parameter set on each press
// and copies the staged set into the active set only on a phase-accumulator
// wrap, so the generated waveform never changes mid-period.
// Ports:
//   clk                 system clock
//   rst_n               asynchronous active-low reset
//   W/A/P/F_key_n       raw keys (wave, amplitude, phase, frequency), active low,
//                       asynchronous to clk
//   dp                  datapath bundle (master side): acc_wrap in, active set
//                       and commit status out, all outputs registered
module sig_gen_param_ctrl #(
  parameter int          DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [31:0] FTW_STEP        = 32'd8590,
  parameter int          A_MAX           = 10,
  parameter int          F_MAX           = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        W_key_n,
  input  logic                        A_key_n,
  input  logic                        P_key_n,
  input  logic                        F_key_n,
  sig_gen_param_ctrl_if.master        dp
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // key bit order: 0 wave, 1 amplitude, 2 phase, 3 frequency
  localparam int KW = 0;
  localparam int KA = 1;
  localparam int KP = 2;
  localparam int KF = 3;

  logic [3:0]       key_raw;
  logic [3:0]       sync_a;
  logic [3:0]       sync_b;
  logic [3:0]       stable;
  logic [3:0]       stable_d;
  logic [3:0]       armed;
  logic [3:0]       press;
  logic [1:0]       fill;
  logic [CNT_W-1:0] db_cnt [4];

  logic [1:0]  st_wave;
  logic [3:0]  st_amp;
  logic [3:0]  st_freq;
  logic [11:0] st_phase;

  logic [1:0]  act_wave;
  logic [3:0]  act_amp;
  logic [3:0]  act_freq;
  logic [11:0] act_phase;
  logic [31:0] act_ftw;
  logic        pending;
  logic        commit;
  logic        commit_q;
  logic        update;
  logic [31:0] ftw_next;

  assign key_raw = {F_key_n, P_key_n, A_key_n, W_key_n};

  // Synchroniser. fill counts the cycles since reset release so that the
  // reset value of the synchroniser is never mistaken for a sampled key level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= '1;
      sync_b <= '1;
      fill   <= 2'd0;
    end else begin
      sync_a <= key_raw;
      sync_b <= sync_a;
      if (fill != 2'd2) fill <= fill + 2'd1;
    end
  end

  // Debounce and press detection. A key only becomes armed once it has been
  // seen released after reset, so a key held through reset release cannot
  // produce a press until it is let go and pressed again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable   <= '1;
      stable_d <= '1;
      armed    <= '0;
      press    <= '0;
      for (int k = 0; k < 4; k++) db_cnt[k] <= '0;
    end else begin
      stable_d <= stable;
      press    <= stable_d & ~stable & armed;
      for (int k = 0; k < 4; k++) begin
        if (sync_b[k] == stable[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == CNT_LAST) begin
          stable[k] <= sync_b[k];
          db_cnt[k] <= '0;
        end else begin
          db_cnt[k] <= db_cnt[k] + CNT_W'(1);
        end
        if (fill == 2'd2 && sync_b[k]) armed[k] <= 1'b1;
      end
    end
  end

  assign commit   = dp.acc_wrap & pending;
  assign ftw_next = 32'(st_freq) * FTW_STEP;

  // Staging and commit. A press and a commit in the same cycle both happen:
  // the commit takes the staged set as it was before this cycle's press, and
  // the press keeps pending set so the new value goes out on the next wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_wave   <= 2'd0;
      st_amp    <= 4'(A_MAX);
      st_freq   <= 4'd1;
      st_phase  <= 12'd0;
      act_wave  <= 2'd0;
      act_amp   <= 4'(A_MAX);
      act_freq  <= 4'd1;
      act_phase <= 12'd0;
      act_ftw   <= FTW_STEP;
      pending   <= 1'b0;
      commit_q  <= 1'b0;
      update    <= 1'b0;
    end else begin
      if (press[KW]) st_wave <= st_wave + 2'd1;
      if (press[KA]) st_amp  <= (st_amp == 4'(A_MAX)) ? 4'd1 : st_amp + 4'd1;
      if (press[KF]) st_freq <= (st_freq == 4'(F_MAX)) ? 4'd1 : st_freq + 4'd1;
      if (press[KP]) st_phase <= st_phase + 12'd1024;

      if (commit) begin
        act_wave  <= st_wave;
        act_amp   <= st_amp;
        act_freq  <= st_freq;
        act_phase <= st_phase;
        act_ftw   <= ftw_next;
      end

      if (|press)      pending <= 1'b1;
      else if (commit) pending <= 1'b0;

      // update trails the active-set load by one cycle
      commit_q <= commit;
      update   <= commit_q;
    end
  end

  assign dp.wave_sel    = act_wave;
  assign dp.amp_level   = act_amp;
  assign dp.freq_level  = act_freq;
  assign dp.phase_off   = act_phase;
  assign dp.ftw         = act_ftw;
  assign dp.cfg_pending = pending;
  assign dp.cfg_update  = update;

endmodule

// File: tb/tb_sig_gen_param_ctrl.sv
module tb_sig_gen_param_ctrl;
  localparam int          DB    = 4;
  localparam logic [31:0] STEP  = 32'd8590;
  localparam int          A_MAX = 10;
  localparam int          F_MAX = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic w_n = 1'b1, a_n = 1'b1, p_n = 1'b1, f_n = 1'b1;

  always #5 clk = ~clk;

  sig_gen_param_ctrl_if bus ();

  sig_gen_param_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .FTW_STEP       (STEP),
    .A_MAX          (A_MAX),
    .F_MAX          (F_MAX)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .W_key_n(w_n),
    .A_key_n(a_n),
    .P_key_n(p_n),
    .F_key_n(f_n),
    .dp     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: index 0 wave, 1 amp, 2 phase, 3 freq (same order as key mask)
  int m_stage [4];
  int m_act   [4];
  bit m_pending;

  function automatic void model_reset();
    m_stage[0] = 0; m_stage[1] = A_MAX; m_stage[2] = 0; m_stage[3] = 1;
    m_act = m_stage;
    m_pending = 1'b0;
  endfunction

  function automatic void model_press(input bit [3:0] mask);
    if (mask[0]) m_stage[0] = (m_stage[0] + 1) % 4;
    if (mask[1]) m_stage[1] = (m_stage[1] % A_MAX) + 1;
    if (mask[2]) m_stage[2] = (m_stage[2] + 1024) % 4096;
    if (mask[3]) m_stage[3] = (m_stage[3] % F_MAX) + 1;
    if (mask != 4'b0) m_pending = 1'b1;
  endfunction

  function automatic void model_wrap();
    if (m_pending) begin
      m_act = m_stage;
      m_pending = 1'b0;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".wave"},    32'(bus.wave_sel),    32'(m_act[0]));
    chk({tag, ".amp"},     32'(bus.amp_level),   32'(m_act[1]));
    chk({tag, ".phase"},   32'(bus.phase_off),   32'(m_act[2]));
    chk({tag, ".freq"},    32'(bus.freq_level),  32'(m_act[3]));
    chk({tag, ".ftw"},     bus.ftw,              32'(m_act[3]) * STEP);
    chk({tag, ".pending"}, 32'(bus.cfg_pending), 32'(m_pending));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_keys(input bit [3:0] low);
    w_n = ~low[0];
    a_n = ~low[1];
    p_n = ~low[2];
    f_n = ~low[3];
  endtask

  // press and release the keys in mask, optionally with short (< DB) bounces
  task automatic press(input bit [3:0] mask, input bit bounce);
    if (bounce) begin
      set_keys(mask);  tick($urandom_range(1, DB - 1));
      set_keys(4'b0);  tick($urandom_range(1, DB - 1));
    end
    set_keys(mask);
    tick(12);
    if (bounce) begin
      set_keys(4'b0);  tick($urandom_range(1, DB - 1));
      set_keys(mask);  tick($urandom_range(1, DB - 1));
    end
    set_keys(4'b0);
    tick(12);
  endtask

  task automatic wrap();
    bus.acc_wrap = 1'b1;
    tick(1);
    bus.acc_wrap = 1'b0;
    tick(3);
  endtask

  initial begin
    bus.acc_wrap = 1'b0;
    model_reset();
    tick(2);
    check_all("reset_hold");
    rst_n = 1'b1;
    tick(5);
    check_all("reset");
    chk("reset.update", 32'(bus.cfg_update), 32'd0);

    // bouncing F key gives exactly one press
    f_n = 1'b0; tick(3);
    f_n = 1'b1; tick(2);
    f_n = 1'b0; tick(20);
    f_n = 1'b1; tick(15);
    model_press(4'b1000);
    check_all("bounce_f");
    bus.acc_wrap = 1'b1;
    tick(1);
    bus.acc_wrap = 1'b0;
    chk("commit.freq", 32'(bus.freq_level), 32'd2);
    chk("commit.ftw", bus.ftw, 32'd17180);
    chk("commit.update_early", 32'(bus.cfg_update), 32'd0);
    tick(1);
    chk("commit.update", 32'(bus.cfg_update), 32'd1);
    tick(1);
    chk("commit.update_end", 32'(bus.cfg_update), 32'd0);
    model_wrap();
    check_all("after_f_commit");

    // wrap with nothing pending is ignored
    wrap();
    chk("idle_wrap.update", 32'(bus.cfg_update), 32'd0);
    check_all("idle_wrap");

    // press latency: staging change visible after edge 2+DB+1+1
    set_keys(4'b0100);
    tick(2 + DB + 1);
    chk("latency.before", 32'(bus.cfg_pending), 32'd0);
    tick(1);
    chk("latency.at", 32'(bus.cfg_pending), 32'd1);
    tick(10);
    set_keys(4'b0);
    tick(12);
    model_press(4'b0100);
    for (int i = 0; i < 3; i++) begin
      press(4'b0100, 1'b0);
      model_press(4'b0100);
    end
    wrap(); model_wrap();
    chk("phase4.off", 32'(bus.phase_off), 32'd0);
    check_all("phase4");
    for (int i = 0; i < 3; i++) begin
      press(4'b0100, 1'b0);
      model_press(4'b0100);
    end
    wrap(); model_wrap();
    chk("phase3.off", 32'(bus.phase_off), 32'd3072);

    // amplitude wrap from A_MAX and five wave presses
    press(4'b0010, 1'b0); model_press(4'b0010);
    for (int i = 0; i < 5; i++) begin
      press(4'b0001, 1'b1);
      model_press(4'b0001);
    end
    wrap(); model_wrap();
    chk("amp_wrap.amp", 32'(bus.amp_level), 32'd1);
    chk("wave5.wave", 32'(bus.wave_sel), 32'd1);
    check_all("amp_wave");

    // simultaneous W and A
    press(4'b0011, 1'b0); model_press(4'b0011);
    check_all("wa_staged");
    wrap(); model_wrap();
    check_all("wa_commit");

    // A press coincident with a commit
    press(4'b0001, 1'b0); model_press(4'b0001);
    set_keys(4'b0010);
    tick(2 + DB + 1);
    bus.acc_wrap = 1'b1;
    tick(1);
    bus.acc_wrap = 1'b0;
    model_wrap();
    model_press(4'b0010);
    check_all("coincident");
    chk("coincident.pending", 32'(bus.cfg_pending), 32'd1);
    tick(10);
    set_keys(4'b0);
    tick(12);
    wrap(); model_wrap();
    check_all("coincident_next");

    // reset while pending and mid-debounce, key held through release
    press(4'b1000, 1'b0); model_press(4'b1000);
    set_keys(4'b0001);
    tick(4);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("mid_reset");
    chk("mid_reset.update", 32'(bus.cfg_update), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(30);
    chk("held_through_reset", 32'(bus.cfg_pending), 32'd0);
    set_keys(4'b0);
    tick(12);
    press(4'b0001, 1'b0); model_press(4'b0001);
    wrap(); model_wrap();
    check_all("after_reset_press");

    // randomized presses and wraps against the model
    for (int i = 0; i < 40; i++) begin
      bit [3:0] mask;
      mask = 4'($urandom_range(1, 15));
      press(mask, 1'($urandom % 2));
      model_press(mask);
      if (($urandom % 2) == 1) begin
        wrap();
        model_wrap();
      end
      check_all($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
